// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared widths, entry layout and tag helpers for the reorder buffer
package reorder_buffer_pkg;

   localparam int TAG_W = 5;
   localparam int DEPTH = 16;
   localparam int IDX_W = 4;
   localparam int CNT_W = 5;
   localparam int REG_W = 5;
   localparam int VAL_W = 32;
   localparam int PC_W  = 32;

   // Tag 0 means "no producer"; entry i carries tag i+1.
   localparam logic [TAG_W-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic             valid;
      logic             ready;
      logic             has_rd;
      logic [REG_W-1:0] rd;
      logic [VAL_W-1:0] value;
      logic             mispredict;
      logic [PC_W-1:0]  target;
   } rob_entry_t;

   function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
      return (tag != TAG_NONE) && (tag <= TAG_W'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
      logic [TAG_W-1:0] w_t;
      w_t = tag - TAG_W'(1);
      return w_t[IDX_W-1:0];
   endfunction

   function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
      return {1'b0, idx} + TAG_W'(1);
   endfunction

endpackage

// File: rtl/rob_youngest_match.sv
// rtl/rob_youngest_match.sv - head-relative scan returning the tag of the youngest matching entry
module rob_youngest_match
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = reorder_buffer_pkg::DEPTH
)(
   input  logic [IDX_W-1:0] i_head,
   input  logic [DEPTH-1:0] i_match,
   output logic [TAG_W-1:0] o_tag
);

   logic [IDX_W-1:0] w_scan_idx;

   // Walk from just after the head towards the tail; the last hit is the youngest.
   always_comb begin
      o_tag      = TAG_NONE;
      w_scan_idx = i_head;
      for (int k = 1; k < DEPTH; k++) begin
         w_scan_idx = i_head + IDX_W'(k);
         if (i_match[w_scan_idx]) begin
            o_tag = idx_to_tag(w_scan_idx);
         end
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry in-order-commit reorder buffer; ROB_BYPASS_EN enables operand lookup
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = reorder_buffer_pkg::DEPTH
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               alloc_valid,
   input  logic               alloc_has_rd,
   input  logic [REG_W-1:0]   alloc_rd,
   output logic               alloc_ready,
   output logic [TAG_W-1:0]   alloc_tag,
   input  logic               wb_valid,
   input  logic [TAG_W-1:0]   wb_tag,
   input  logic [VAL_W-1:0]   wb_value,
   input  logic               wb_mispredict,
   input  logic [PC_W-1:0]    wb_target,
   input  logic [TAG_W-1:0]   query_tag,
   output logic               query_ready,
   output logic [VAL_W-1:0]   query_value,
   output logic               rf_we,
   output logic [REG_W-1:0]   rf_waddr,
   output logic [TAG_W+VAL_W-1:0] rf_wdata,
   output logic               flush,
   output logic [PC_W-1:0]    flush_pc
);

   rob_entry_t       r_ent [DEPTH];
   logic [IDX_W-1:0] r_head;
   logic [IDX_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_flush;
   logic [PC_W-1:0]  r_flush_pc;

   rob_entry_t       w_head_ent;
   logic             w_full;
   logic             w_commit;
   logic             w_redirect;
   logic             w_alloc;
   logic [IDX_W-1:0] w_wb_idx;
   logic             w_wb_hit;
   logic             w_wb_take;
   logic [DEPTH-1:0] w_match;
   logic [TAG_W-1:0] w_pend_tag;

   assign w_head_ent = r_ent[r_head];
   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_commit   = !rst && rdy && !r_flush && w_head_ent.valid && w_head_ent.ready;
   assign w_redirect = w_commit && w_head_ent.mispredict;

   // A commit frees the head slot in the same cycle, so a full buffer still accepts.
   assign alloc_ready = !rst && rdy && !r_flush && (!w_full || w_commit);
   assign alloc_tag   = idx_to_tag(r_tail);
   assign w_alloc     = alloc_valid && alloc_ready;

   assign w_wb_idx  = tag_to_idx(wb_tag);
   assign w_wb_hit  = wb_valid && tag_in_range(wb_tag) && r_ent[w_wb_idx].valid;
   assign w_wb_take = w_wb_hit && rdy && !r_flush;

   // Other in-flight writers of the committing register, used for the pending tag.
   always_comb begin
      w_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_match[i] = r_ent[i].valid && r_ent[i].has_rd && (r_ent[i].rd == w_head_ent.rd);
      end
   end

   rob_youngest_match #(
      .DEPTH (DEPTH)
   ) u_youngest (
      .i_head  (r_head),
      .i_match (w_match),
      .o_tag   (w_pend_tag)
   );

   assign rf_we    = w_commit && w_head_ent.has_rd && (w_head_ent.rd != '0);
   assign rf_waddr = w_head_ent.rd;
   assign rf_wdata = {w_pend_tag, w_head_ent.value};
   assign flush    = r_flush;
   assign flush_pc = r_flush_pc;

   // Pointers, occupancy and the one-cycle redirect pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_flush    <= 1'b0;
         r_flush_pc <= '0;
      end else if (rdy) begin
         r_flush <= 1'b0;
         if (w_redirect) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_flush    <= 1'b1;
            r_flush_pc <= w_head_ent.target;
         end else begin
            if (w_commit) r_head <= r_head + IDX_W'(1);
            if (w_alloc)  r_tail <= r_tail + IDX_W'(1);
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_commit);
         end
      end
   end

   // Entry storage: writeback, retire, allocate, then a redirect wipes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ent[i].valid <= 1'b0;
         end
      end else if (rdy && !r_flush) begin
         if (w_wb_take) begin
            r_ent[w_wb_idx].ready      <= 1'b1;
            r_ent[w_wb_idx].value      <= wb_value;
            r_ent[w_wb_idx].mispredict <= wb_mispredict;
            r_ent[w_wb_idx].target     <= wb_target;
         end
         if (w_commit) begin
            r_ent[r_head].valid <= 1'b0;
         end
         if (w_alloc) begin
            r_ent[r_tail].valid  <= 1'b1;
            r_ent[r_tail].ready  <= 1'b0;
            r_ent[r_tail].has_rd <= alloc_has_rd;
            r_ent[r_tail].rd     <= alloc_rd;
         end
         if (w_redirect) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_ent[i].valid <= 1'b0;
            end
         end
      end
   end

`ifdef ROB_BYPASS_EN
   logic [IDX_W-1:0] w_q_idx;
   logic             w_q_valid;
   logic             w_q_fwd;

   assign w_q_idx     = tag_to_idx(query_tag);
   assign w_q_valid   = !rst && tag_in_range(query_tag) && r_ent[w_q_idx].valid;
   assign w_q_fwd     = wb_valid && (wb_tag == query_tag);
   assign query_ready = w_q_valid && (r_ent[w_q_idx].ready || w_q_fwd);
   assign query_value = w_q_fwd ? wb_value : r_ent[w_q_idx].value;
`else
   logic w_unused_query;
   assign w_unused_query = ^query_tag;
   assign query_ready    = 1'b0;
   assign query_value    = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer against a queue-based model
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        alloc_valid;
   logic        alloc_has_rd;
   logic [4:0]  alloc_rd;
   logic        alloc_ready;
   logic [4:0]  alloc_tag;
   logic        wb_valid;
   logic [4:0]  wb_tag;
   logic [31:0] wb_value;
   logic        wb_mispredict;
   logic [31:0] wb_target;
   logic [4:0]  query_tag;
   logic        query_ready;
   logic [31:0] query_value;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [36:0] rf_wdata;
   logic        flush;
   logic [31:0] flush_pc;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .alloc_valid   (alloc_valid),
      .alloc_has_rd  (alloc_has_rd),
      .alloc_rd      (alloc_rd),
      .alloc_ready   (alloc_ready),
      .alloc_tag     (alloc_tag),
      .wb_valid      (wb_valid),
      .wb_tag        (wb_tag),
      .wb_value      (wb_value),
      .wb_mispredict (wb_mispredict),
      .wb_target     (wb_target),
      .query_tag     (query_tag),
      .query_ready   (query_ready),
      .query_value   (query_value),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .flush         (flush),
      .flush_pc      (flush_pc)
   );

   typedef struct {
      logic [4:0]  tag;
      bit          has_rd;
      logic [4:0]  rd;
      bit          done;
      logic [31:0] value;
      bit          misp;
      logic [31:0] target;
   } ins_t;

   typedef struct {
      logic [4:0]  waddr;
      logic [36:0] wdata;
   } rfw_t;

   ins_t        m_q[$];
   logic [4:0]  m_next_tag;
   bit          m_flush;
   logic [31:0] m_flush_pc;
   rfw_t        exp_rf[$];
   logic [31:0] exp_flush[$];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: mid-cycle, every commit write and flush pulse must match the scoreboard.
   initial begin
      rfw_t        e;
      logic [31:0] epc;
      bit          exp_we;
      bit          exp_fl;
      forever begin
         @(negedge clk);
         #3;
         if (mon_en && !rst) begin
            exp_we = (exp_rf.size() != 0);
            if (exp_we || rf_we) begin
               chk("rf_we", 64'(rf_we), 64'(exp_we));
               if (exp_we) begin
                  e = exp_rf.pop_front();
                  if (rf_we) begin
                     chk("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
                     chk("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
                  end
               end
            end
            exp_fl = (exp_flush.size() != 0);
            if (exp_fl || flush) begin
               chk("flush", 64'(flush), 64'(exp_fl));
               if (exp_fl) begin
                  epc = exp_flush.pop_front();
                  if (flush) chk("flush_pc", 64'(flush_pc), 64'(epc));
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic model_reset();
      m_q.delete();
      m_next_tag = 5'd1;
      m_flush    = 1'b0;
      m_flush_pc = '0;
   endtask

   task automatic step(input bit i_rdy, input bit av, input bit ahrd, input logic [4:0] ard,
                       input bit wv, input logic [4:0] wt, input logic [31:0] wval,
                       input bit wm, input logic [31:0] wtg, input logic [4:0] qt);
      bit          commit;
      bit          ar;
      bit          qr;
      bit          fwd;
      logic [31:0] qv;
      logic [4:0]  pend;
      ins_t        c;
      @(negedge clk);
      rdy = i_rdy; alloc_valid = av; alloc_has_rd = ahrd; alloc_rd = ard;
      wb_valid = wv; wb_tag = wt; wb_value = wval; wb_mispredict = wm; wb_target = wtg;
      query_tag = qt;
      #1;
      if (m_flush) exp_flush.push_back(m_flush_pc);
      commit = !m_flush && i_rdy && (m_q.size() > 0) && m_q[0].done;
      ar = i_rdy && !m_flush && ((m_q.size() < 16) || commit);
      chk("alloc_ready", 64'(alloc_ready), 64'(ar));
      chk("alloc_tag", 64'(alloc_tag), 64'(m_next_tag));
`ifdef ROB_BYPASS_EN
      qr = 1'b0;
      qv = '0;
      foreach (m_q[k]) begin
         if (qt != 5'd0 && m_q[k].tag == qt) begin
            fwd = wv && (wt == qt);
            qr  = m_q[k].done || fwd;
            qv  = fwd ? wval : m_q[k].value;
         end
      end
      chk("query_ready", 64'(query_ready), 64'(qr));
      if (qr) chk("query_value", 64'(query_value), 64'(qv));
`else
      qr  = 1'b0;
      qv  = '0;
      fwd = 1'b0;
      chk("query_ready", 64'(query_ready), 64'(qr));
      chk("query_value", 64'(query_value), 64'(qv));
`endif
      if (commit) begin
         c = m_q.pop_front();
         if (c.has_rd && c.rd != 5'd0) begin
            pend = 5'd0;
            foreach (m_q[k]) if (m_q[k].has_rd && m_q[k].rd == c.rd) pend = m_q[k].tag;
            exp_rf.push_back('{waddr: c.rd, wdata: {pend, c.value}});
         end
      end
      if (i_rdy && !m_flush && wv) begin
         foreach (m_q[k]) begin
            if (m_q[k].tag == wt) begin
               m_q[k].done = 1'b1; m_q[k].value = wval; m_q[k].misp = wm; m_q[k].target = wtg;
            end
         end
      end
      if (av && ar) begin
         m_q.push_back('{tag: m_next_tag, has_rd: ahrd, rd: ard, done: 1'b0,
                         value: 32'd0, misp: 1'b0, target: 32'd0});
         m_next_tag = (m_next_tag == 5'd16) ? 5'd1 : m_next_tag + 5'd1;
      end
      if (i_rdy) begin
         if (commit && c.misp) begin
            m_q.delete();
            m_next_tag = 5'd1;
            m_flush    = 1'b1;
            m_flush_pc = c.target;
         end else begin
            m_flush = 1'b0;
         end
      end
   endtask

   task automatic idle();
      step(1, 0, 0, 5'd0, 0, 5'd0, 32'd0, 0, 32'd0, 5'd0);
   endtask

   task automatic alloc(input bit hrd, input logic [4:0] rd);
      step(1, 1, hrd, rd, 0, 5'd0, 32'd0, 0, 32'd0, 5'd0);
   endtask

   task automatic wb(input logic [4:0] t, input logic [31:0] v, input bit m, input logic [31:0] tg);
      step(1, 0, 0, 5'd0, 1, t, v, m, tg, 5'd0);
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && (m_q.size() != 0 || m_flush); n++) begin
         if (m_q.size() != 0 && !m_q[0].done) wb(m_q[0].tag, $urandom, 0, 32'd0);
         else idle();
      end
      idle();
      idle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; rdy = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("reset_rf_we", 64'(rf_we), 64'(0));
      chk("reset_query_ready", 64'(query_ready), 64'(0));
      chk("reset_alloc_tag", 64'(alloc_tag), 64'(1));
      chk("reset_flush", 64'(flush), 64'(0));
      chk("reset_flush_pc", 64'(flush_pc), 64'(0));
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      bit         r;
      logic [4:0] wt;
      logic [4:0] qt;
      rst = 1'b1; rdy = 1'b0; alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_rd = '0;
      wb_valid = 1'b0; wb_tag = '0; wb_value = '0; wb_mispredict = 1'b0; wb_target = '0;
      query_tag = '0;
      model_reset();
      do_reset();
      mon_en = 1'b1;

      // Three allocations, out-of-order completion, pending tag on the first commit.
      alloc(1, 5'd5); alloc(1, 5'd6); alloc(1, 5'd5);
      wb(5'd2, 32'hAA, 0, 0);
      wb(5'd1, 32'h11, 0, 0);
      idle(); idle();
      wb(5'd3, 32'h33, 0, 0);
      idle();

      // rd=0 commit never writes; rdy low stalls a ready head.
      alloc(1, 5'd0);
      wb(m_q[0].tag, 32'h77, 0, 0);
      idle();
      alloc(1, 5'd7);
      wb(m_q[0].tag, 32'h99, 0, 0);
      step(0, 1, 1, 5'd3, 0, 5'd0, 32'd0, 0, 32'd0, 5'd0);
      step(0, 0, 0, 5'd0, 0, 5'd0, 32'd0, 0, 32'd0, 5'd0);
      idle();
      drain();

      // Full buffer, then commit and allocate together.
      do_reset();
      for (int i = 0; i < 16; i++) alloc(1, 5'(i % 4 + 1));
      step(1, 1, 1, 5'd9, 1, 5'd1, 32'h1234, 0, 32'd0, 5'd0);
      alloc(1, 5'd9);
      drain();

      // Mispredict redirect; alloc and wb during the flush cycle are dropped.
      do_reset();
      for (int i = 0; i < 4; i++) alloc(1, 5'(i + 2));
      wb(5'd1, 32'h5A5A, 1, 32'h100);
      idle();
      step(1, 1, 1, 5'd4, 1, 5'd2, 32'hDEAD, 0, 32'd0, 5'd0);
      alloc(1, 5'd4);
      drain();

      // Operand lookup with same-cycle forwarding.
      do_reset();
      alloc(1, 5'd1); alloc(1, 5'd2);
      step(1, 0, 0, 5'd0, 1, 5'd2, 32'h55, 0, 32'd0, 5'd2);
      step(1, 0, 0, 5'd0, 0, 5'd0, 32'd0, 0, 32'd0, 5'd2);
      drain();

      // Randomised traffic.
      for (int n = 0; n < 800; n++) begin
         r = m_flush ? 1'b1 : ($urandom_range(0, 7) != 0);
         if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
            wt = m_q[$urandom_range(0, m_q.size() - 1)].tag;
         else
            wt = 5'($urandom_range(0, 16));
         if (m_q.size() > 0 && $urandom_range(0, 1) != 0)
            qt = m_q[$urandom_range(0, m_q.size() - 1)].tag;
         else
            qt = 5'($urandom_range(0, 16));
         step(r, $urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
              $urandom_range(0, 1) != 0, wt, $urandom, $urandom_range(0, 19) == 0, $urandom, qt);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
